// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one byte-addressable data memory between port A and port B.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned word accesses as errors.
module data_memory_arbiter #(
  parameter int MEM_BYTES  = 8192,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  aReq,
  input  logic [ADDR_WIDTH-1:0] aAddr,
  input  logic [DATA_WIDTH-1:0] aWriteData,
  input  logic                  aWe,
  input  logic                  aSb,
  output logic                  aDone,
  output logic [DATA_WIDTH-1:0] aReadData,
  output logic                  aErr,
  input  logic                  bReq,
  input  logic [ADDR_WIDTH-1:0] bAddr,
  input  logic [DATA_WIDTH-1:0] bWriteData,
  input  logic                  bWe,
  input  logic                  bSb,
  output logic                  bDone,
  output logic [DATA_WIDTH-1:0] bReadData,
  output logic                  bErr,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  memWrite,
  output logic                  memSb,
  input  logic [DATA_WIDTH-1:0] memReadData,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(MEM_BYTES - 4);
  localparam logic [ADDR_WIDTH-1:0] BYTE_LIMIT = ADDR_WIDTH'(MEM_BYTES - 1);

  state_t                state, nextState;
  logic                  lastGrant, owner;
  logic                  latWe, latSb, latErr;
  logic                  grant, winner;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWriteData;
  logic                  selWe, selSb, selErr;

  // NOTE: every signal gets a default first so no path through the block leaves it unassigned (no latches).
  always_comb begin
    nextState = state;
    grant     = 1'b0;
    winner    = PORT_A;
    if (aReq && bReq) winner = (lastGrant == PORT_B) ? PORT_A : PORT_B;
    else if (bReq)    winner = PORT_B;
    case (state)
      IDLE: begin
        if (aReq || bReq) begin
          nextState = ACCESS;
          grant     = 1'b1;
        end
      end
      ACCESS:  nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    selAddr      = (winner == PORT_B) ? bAddr      : aAddr;
    selWriteData = (winner == PORT_B) ? bWriteData : aWriteData;
    selWe        = (winner == PORT_B) ? bWe        : aWe;
    selSb        = (winner == PORT_B) ? bSb        : aSb;
    if (selWe && selSb) selErr = (selAddr > BYTE_LIMIT);
    else                selErr = (selAddr > WORD_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    if (!(selWe && selSb) && (selAddr[1:0] != 2'b00)) selErr = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      lastGrant    <= PORT_B;
      owner        <= PORT_A;
      latWe        <= 1'b0;
      latSb        <= 1'b0;
      latErr       <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      aDone        <= 1'b0;
      bDone        <= 1'b0;
      aErr         <= 1'b0;
      bErr         <= 1'b0;
      aReadData    <= '0;
      bReadData    <= '0;
    end else begin
      state <= nextState;
      aDone <= 1'b0;
      bDone <= 1'b0;
      aErr  <= 1'b0;
      bErr  <= 1'b0;
      // memAddress/memWriteData double as the latched request fields and hold between accesses.
      if (grant) begin
        owner        <= winner;
        lastGrant    <= winner;
        memAddress   <= selAddr;
        memWriteData <= selWriteData;
        latWe        <= selWe;
        latSb        <= selSb;
        latErr       <= selErr;
      end
      if (state == ACCESS) begin
        if (owner == PORT_A) begin
          aDone <= 1'b1;
          aErr  <= latErr;
          if (!latWe) aReadData <= latErr ? '0 : memReadData;
        end else begin
          bDone <= 1'b1;
          bErr  <= latErr;
          if (!latWe) bReadData <= latErr ? '0 : memReadData;
        end
      end
    end
  end

  // Reset gates the strobes combinationally so a reset during ACCESS cannot commit a write.
  assign memWrite = (state == ACCESS) && latWe && !latErr && !reset;
  assign memSb    = (state == ACCESS) && latSb && !reset;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level reference model and a byte-array memory.
module tb_data_memory_arbiter;
  localparam int MEM_BYTES = 8192;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          aReq, aWe, aSb, aDone, aErr;
  logic [AW-1:0] aAddr;
  logic [DW-1:0] aWriteData, aReadData;
  logic          bReq, bWe, bSb, bDone, bErr;
  logic [AW-1:0] bAddr;
  logic [DW-1:0] bWriteData, bReadData;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData, memReadData;
  logic          memWrite, memSb, busy;

  int nChecks = 0;
  int nFail   = 0;
  bit checkOn = 1'b0;
  bit memClear;
  int mwCount = 0;

  always #5 clock = ~clock;

  data_memory_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .aReq(aReq), .aAddr(aAddr), .aWriteData(aWriteData), .aWe(aWe), .aSb(aSb),
    .aDone(aDone), .aReadData(aReadData), .aErr(aErr),
    .bReq(bReq), .bAddr(bAddr), .bWriteData(bWriteData), .bWe(bWe), .bSb(bSb),
    .bDone(bDone), .bReadData(bReadData), .bErr(bErr),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWrite(memWrite),
    .memSb(memSb), .memReadData(memReadData), .busy(busy)
  );

  // Memory device seen by the DUT: combinational little-endian read, write on the rising edge.
  logic [7:0]  devMem [0:MEM_BYTES+2];
  logic [12:0] devIdx;
  assign devIdx = memAddress[12:0];
  assign memReadData = {devMem[int'(devIdx)+3], devMem[int'(devIdx)+2],
                        devMem[int'(devIdx)+1], devMem[int'(devIdx)]};

  always @(posedge clock) begin
    if (memClear) begin
      for (int i = 0; i < MEM_BYTES + 3; i++) devMem[i] <= 8'(i * 37 + 11);
    end else if (memWrite) begin
      if (memSb) devMem[devIdx] <= memWriteData[7:0];
      else for (int k = 0; k < 4; k++) devMem[int'(devIdx)+k] <= memWriteData[8*k +: 8];
    end
  end

  always @(negedge clock) if (memWrite) mwCount++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model (transaction level) ----------------
  logic [7:0]  refMem [0:MEM_BYTES-1];
  int          edgeNo = 0;
  int          grantEdge = -10;
  int          freeAt = 0;
  bit          inFlight = 0;
  bit          fOwner, fWe, fSb, fErr;
  logic [31:0] fAddr, fWdata;
  bit          lastB = 1;
  bit          expADone, expBDone, expAErr, expBErr, expAccess, expBusy;
  logic [31:0] expARd = 0, expBRd = 0;

  function automatic bit model_err(input logic [31:0] ad, input bit we, input bit sb);
    if (we && sb) return longint'(ad) >= MEM_BYTES;
`ifdef DMEM_ALIGN_CHECK_EN
    if (ad[1:0] != 2'b00) return 1'b1;
`endif
    return (longint'(ad) + 4) > MEM_BYTES;
  endfunction

  always @(posedge clock) begin
    logic [31:0] rd;
    bit          win;
    edgeNo++;
    expADone = 0; expBDone = 0; expAErr = 0; expBErr = 0; expAccess = 0; expBusy = 0;
    if (memClear) for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'(i * 37 + 11);
    if (reset) begin
      inFlight = 0; lastB = 1; expARd = 0; expBRd = 0; freeAt = edgeNo + 1;
    end else begin
      if (inFlight && edgeNo == grantEdge + 1) begin
        inFlight = 0;
        expBusy  = 1;
        if (fWe) begin
          if (!fErr) begin
            if (fSb) refMem[fAddr] = fWdata[7:0];
            else for (int k = 0; k < 4; k++) refMem[fAddr+k] = fWdata[8*k +: 8];
          end
        end else begin
          rd = 0;
          if (!fErr) for (int k = 0; k < 4; k++) rd[8*k +: 8] = refMem[fAddr+k];
          if (fOwner) expBRd = rd; else expARd = rd;
        end
        if (fOwner) begin expBDone = 1; expBErr = fErr; end
        else        begin expADone = 1; expAErr = fErr; end
      end
      if (edgeNo >= freeAt && (aReq || bReq)) begin
        win = (aReq && bReq) ? !lastB : bReq;
        fOwner = win; lastB = win;
        fAddr  = win ? bAddr : aAddr;
        fWdata = win ? bWriteData : aWriteData;
        fWe    = win ? bWe : aWe;
        fSb    = win ? bSb : aSb;
        fErr   = model_err(fAddr, fWe, fSb);
        inFlight = 1; grantEdge = edgeNo; freeAt = edgeNo + 3;
        expAccess = 1; expBusy = 1;
      end
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clock) begin
    if (checkOn) begin
      check("aDone", aDone, expADone);
      check("bDone", bDone, expBDone);
      check("aErr", aErr, expAErr);
      check("bErr", bErr, expBErr);
      check("aReadData", aReadData, expARd);
      check("bReadData", bReadData, expBRd);
      check("busy", busy, expBusy);
      check("memWrite", memWrite, expAccess && fWe && !fErr && !reset);
      if (expAccess) begin
        check("memAddress", memAddress, fAddr);
        check("memWriteData", memWriteData, fWdata);
        check("memSb", memSb, fSb && !reset);
      end else begin
        check("memSb_idle", memSb, 0);
      end
    end
  end

  // ---------------- Directed helpers ----------------
  task automatic access(input bit p, input logic [31:0] ad, input logic [31:0] wd,
                        input bit we, input bit sb,
                        output logic [31:0] rd, output bit er, output int lat);
    @(posedge clock); #1;
    if (!p) begin aReq = 1; aAddr = ad; aWriteData = wd; aWe = we; aSb = sb; end
    else    begin bReq = 1; bAddr = ad; bWriteData = wd; bWe = we; bSb = sb; end
    lat = 0; rd = 0; er = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if ((!p && aDone) || (p && bDone)) begin
        lat = i;
        rd  = p ? bReadData : aReadData;
        er  = p ? bErr : aErr;
        break;
      end
    end
    if (!p) aReq = 0; else bReq = 0;
    check("done_seen", lat != 0, 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    reset = 1; aReq = 0; bReq = 0;
    repeat (n) @(posedge clock);
    #1 reset = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] ad;
    case ($urandom_range(0, 3))
      0:       ad = $urandom_range(0, 255);
      1:       ad = MEM_BYTES - $urandom_range(1, 8);
      2:       ad = $urandom_range(0, MEM_BYTES - 1);
      default: ad = $urandom;
    endcase
    if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
    return ad;
  endfunction

  // ---------------- Stimulus ----------------
  initial begin
    logic [31:0] rd;
    bit          er, bothSeen;
    int          lat, mw0, aCnt, bCnt;
    int          order[$];

    reset = 1; memClear = 1;
    aReq = 0; aAddr = 0; aWriteData = 0; aWe = 0; aSb = 0;
    bReq = 0; bAddr = 0; bWriteData = 0; bWe = 0; bSb = 0;
    @(posedge clock); #1;
    memClear = 0; checkOn = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check("rst_aDone", aDone, 0);
    check("rst_busy", busy, 0);
    check("rst_memWrite", memWrite, 0);
    check("rst_memAddress", memAddress, 0);
    check("rst_aReadData", aReadData, 0);

    // Word write then read-back on port A.
    mw0 = mwCount;
    access(0, 32'h10, 32'hDEADBEEF, 1, 0, rd, er, lat);
    check("wr_latency", lat, 2);
    check("wr_pulses", mwCount - mw0, 1);
    check("wr_err", er, 0);
    access(0, 32'h10, 32'h0, 0, 0, rd, er, lat);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", er, 0);

    // Contention straight after reset: A, B, A, B.
    do_reset(2);
    @(posedge clock); #1;
    aReq = 1; aAddr = 32'h10; aWe = 0; aSb = 0;
    bReq = 1; bAddr = 32'h14; bWe = 0; bSb = 0;
    aCnt = 0; bCnt = 0; bothSeen = 0;
    for (int i = 0; i < 40 && (aCnt < 2 || bCnt < 2); i++) begin
      @(posedge clock); #1;
      if (aDone && bDone) bothSeen = 1;
      if (aDone) begin order.push_back(0); aCnt++; if (aCnt == 2) aReq = 0; end
      if (bDone) begin order.push_back(1); bCnt++; if (bCnt == 2) bReq = 0; end
    end
    aReq = 0; bReq = 0;
    check("rr_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) check("rr_order", order[i], i % 2);
    check("rr_both_done", bothSeen, 0);

    // Byte store from B into a word written by A.
    access(0, 32'h20, 32'h11223344, 1, 0, rd, er, lat);
    access(1, 32'h21, 32'h000000AA, 1, 1, rd, er, lat);
    access(0, 32'h20, 32'h0, 0, 0, rd, er, lat);
    check("sb_merge", rd, 32'h1122AA44);

    // Range boundaries.
    mw0 = mwCount;
    access(0, MEM_BYTES - 2, 32'h12345678, 1, 0, rd, er, lat);
    check("range_word_err", er, 1);
    check("range_word_nowr", mwCount - mw0, 0);
    access(0, MEM_BYTES - 1, 32'h00000055, 1, 1, rd, er, lat);
    check("range_byte_err", er, 0);
    check("range_byte_wr", mwCount - mw0, 1);

    // Reset during ACCESS aborts the write.
    access(0, 32'h40, 32'h01020304, 1, 0, rd, er, lat);
    access(0, 32'h44, 32'h0A0B0C0D, 1, 0, rd, er, lat);
    @(posedge clock); #1;
    aReq = 1; aAddr = 32'h40; aWriteData = 32'hFFFFFFFF; aWe = 1; aSb = 0;
    @(posedge clock); #1;
    reset = 1; aReq = 0;
    @(negedge clock);
    check("abort_memWrite", memWrite, 0);
    @(posedge clock); #1;
    reset = 0;
    check("abort_busy", busy, 0);
    check("abort_done", aDone, 0);
    @(posedge clock); #1;
    check("abort_done2", aDone, 0);
    access(0, 32'h40, 32'h0, 0, 0, rd, er, lat);
    check("abort_mem", rd, 32'h01020304);

    // Misaligned word read.
    access(0, 32'h42, 32'h0, 0, 0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("misalign_err", er, 1);
    check("misalign_data", rd, 32'h0);
`else
    check("misalign_err", er, 0);
    check("misalign_data", rd, 32'h0C0D0102);
`endif

    // Randomized traffic with occasional resets and post-grant field changes.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 299) == 0);
      if (aReq && aDone) aReq = 0;
      else if (aReq && inFlight && !fOwner && $urandom_range(0, 1) == 1) begin
        aAddr = $urandom; aWriteData = $urandom; aWe = 1'($urandom); aSb = 1'($urandom);
      end else if (!aReq && $urandom_range(0, 2) == 0) begin
        aReq = 1; aAddr = rand_addr(); aWriteData = $urandom;
        aWe = 1'($urandom); aSb = 1'($urandom);
      end
      if (bReq && bDone) bReq = 0;
      else if (bReq && inFlight && fOwner && $urandom_range(0, 1) == 1) begin
        bAddr = $urandom; bWriteData = $urandom; bWe = 1'($urandom); bSb = 1'($urandom);
      end else if (!bReq && $urandom_range(0, 2) == 0) begin
        bReq = 1; bAddr = rand_addr(); bWriteData = $urandom;
        bWe = 1'($urandom); bSb = 1'($urandom);
      end
    end
    @(posedge clock); #1;
    reset = 0; aReq = 0; bReq = 0;
    repeat (6) @(posedge clock);
    #1;
    for (int i = 0; i < MEM_BYTES; i += 97) check("mem_image", devMem[i], refMem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
